// File: rtl/clock_divider_multi_if.sv
// Bus bundle for clock_divider_multi: enables, half-period write port and per-channel outputs.
// CLKDIV_SYNC_CLEAR_EN adds the sync_clr input to the bundle.
interface clock_divider_multi_if #(
  parameter int NUM_CH    = 4,
  parameter int CH_SEL_W  = 2,
  parameter int BIT_WIDTH = 32
);
  logic [NUM_CH-1:0]    ch_en;
  logic                 wr_en;
  logic [CH_SEL_W-1:0]  wr_ch;
  logic [BIT_WIDTH-1:0] wr_data;
`ifdef CLKDIV_SYNC_CLEAR_EN
  logic                 sync_clr;
`endif
  logic [NUM_CH-1:0]    c0;
  logic [NUM_CH-1:0]    tick;
  logic [NUM_CH-1:0]    locked;

`ifdef CLKDIV_SYNC_CLEAR_EN
  modport master (output ch_en, wr_en, wr_ch, wr_data, sync_clr, input c0, tick, locked);
  modport slave  (input ch_en, wr_en, wr_ch, wr_data, sync_clr, output c0, tick, locked);
`else
  modport master (output ch_en, wr_en, wr_ch, wr_data, input c0, tick, locked);
  modport slave  (input ch_en, wr_en, wr_ch, wr_data, output c0, tick, locked);
`endif
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent dividers with runtime half-period.
// Optional CLKDIV_SYNC_CLEAR_EN adds sync_clr to phase-align all enabled channels.
module clkdiv_ch #(
  parameter int                   BIT_WIDTH    = 32,
  parameter logic [BIT_WIDTH-1:0] DEFAULT_HALF = '0
) (
  input  logic                 inclk0,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 wr_i,
  input  logic [BIT_WIDTH-1:0] wr_data_i,
  input  logic                 sync_clr_i,
  output logic                 c0_o,
  output logic                 tick_o,
  output logic                 locked_o
);
  logic [BIT_WIDTH-1:0] cnt_q, cnt_d, act_q, act_d, pend_q, pend_d;
  logic                 c0_q, c0_d, tick_q, tick_d, lock_q, lock_d;

  always_comb begin
    pend_d = wr_i ? wr_data_i : pend_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    c0_d   = c0_q;
    tick_d = 1'b0;
    lock_d = lock_q & ~wr_i;   // any new period is unconfirmed until the next rise
    if (!en_i) begin
      cnt_d  = pend_d;
      act_d  = pend_d;
      c0_d   = 1'b0;
      lock_d = 1'b0;
    end else if (sync_clr_i) begin
      cnt_d = act_q;
      c0_d  = 1'b0;
    end else if (cnt_q == '0) begin
      // pend_d carries a same-cycle write straight into the next half
      c0_d   = ~c0_q;
      tick_d = ~c0_q;
      cnt_d  = pend_d;
      act_d  = pend_d;
      if (!c0_q && !wr_i) lock_d = 1'b1;
    end else begin
      cnt_d = cnt_q - BIT_WIDTH'(1);
    end
  end

  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= DEFAULT_HALF;
      act_q  <= DEFAULT_HALF;
      pend_q <= DEFAULT_HALF;
      c0_q   <= 1'b0;
      tick_q <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      c0_q   <= c0_d;
      tick_q <= tick_d;
      lock_q <= lock_d;
    end
  end

  assign c0_o     = c0_q;
  assign tick_o   = tick_q;
  assign locked_o = lock_q;
endmodule

module clock_divider_multi #(
  parameter int BIT_WIDTH    = 32,
  parameter int NUM_CH       = 4,
  parameter int CH_SEL_W     = 2,
  parameter int DEFAULT_HALF = 2500000
) (
  input  logic                inclk0,
  input  logic                rst_n,
  clock_divider_multi_if.slave bus
);
  logic [NUM_CH-1:0] c0_w, tick_w, lock_w;
  logic              sclr;

`ifdef CLKDIV_SYNC_CLEAR_EN
  assign sclr = bus.sync_clr;
`else
  assign sclr = 1'b0;
`endif

  // Channel indices >= NUM_CH match no decoder, so such writes are dropped
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_ch #(
      .BIT_WIDTH    (BIT_WIDTH),
      .DEFAULT_HALF (BIT_WIDTH'(DEFAULT_HALF))
    ) u_ch (
      .inclk0     (inclk0),
      .rst_n      (rst_n),
      .en_i       (bus.ch_en[i]),
      .wr_i       (bus.wr_en && (bus.wr_ch == CH_SEL_W'(i))),
      .wr_data_i  (bus.wr_data),
      .sync_clr_i (sclr),
      .c0_o       (c0_w[i]),
      .tick_o     (tick_w[i]),
      .locked_o   (lock_w[i])
    );
  end

  assign bus.c0     = c0_w;
  assign bus.tick   = tick_w;
  assign bus.locked = lock_w;
endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: vector tables plus hand-built corner sequences,
// expected outputs queued at drive time and compared on the following falling edge.
module tb_clock_divider_multi;
  localparam int BW = 8, NC = 4, CW = 3, DH = 3;

  logic inclk0 = 1'b0;
  logic rst_n  = 1'b0;
  always #5 inclk0 = ~inclk0;

  clock_divider_multi_if #(.NUM_CH(NC), .CH_SEL_W(CW), .BIT_WIDTH(BW)) bus ();

  clock_divider_multi #(
    .BIT_WIDTH(BW), .NUM_CH(NC), .CH_SEL_W(CW), .DEFAULT_HALF(DH)
  ) dut (
    .inclk0 (inclk0),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [NC-1:0] en;
    logic          we;
    logic [CW-1:0] ch;
    logic [BW-1:0] data;
    logic          clr;
    logic [NC-1:0] c0, tick, lock;
  } vec_t;

  typedef struct {
    int            due;
    logic [NC-1:0] c0, tick, lock;
    string         name;
  } exp_t;

  exp_t sb[$];
  exp_t ck_e;
  vec_t ta[$], tb_v[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0;

  always @(posedge inclk0) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  always @(negedge inclk0) begin
    if (sb.size() != 0 && sb[0].due == cyc) begin
      ck_e = sb.pop_front();
      check({ck_e.name, " c0"},     bus.c0,     ck_e.c0);
      check({ck_e.name, " tick"},   bus.tick,   ck_e.tick);
      check({ck_e.name, " locked"}, bus.locked, ck_e.lock);
    end
  end

  // Steady-state waveform of a channel n cycles after it starts counting from a full half H
  function automatic logic [2:0] run_exp(input int n, input int h);
    int p;
    if (n < h + 1) return 3'b000;
    p = n - (h + 1);
    return {((p / (h + 1)) % 2 == 0), (p % (2 * (h + 1)) == 0), 1'b1};
  endfunction

  function automatic vec_t mk(input logic [NC-1:0] en, input logic we, input logic [CW-1:0] ch,
                              input logic [BW-1:0] data, input logic clr,
                              input logic [NC-1:0] c0, input logic [NC-1:0] tick,
                              input logic [NC-1:0] lock);
    vec_t v;
    v.en = en; v.we = we; v.ch = ch; v.data = data; v.clr = clr;
    v.c0 = c0; v.tick = tick; v.lock = lock;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    @(posedge inclk0); #1;
    bus.ch_en   = v.en;
    bus.wr_en   = v.we;
    bus.wr_ch   = v.ch;
    bus.wr_data = v.data;
`ifdef CLKDIV_SYNC_CLEAR_EN
    bus.sync_clr = v.clr;
`endif
    e.due = cyc + 1; e.c0 = v.c0; e.tick = v.tick; e.lock = v.lock; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 4; i++) begin
      if (sb.size() == 0) break;
      @(negedge inclk0); #1;
    end
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else begin
      $display("FAIL %s drain: %0d results pending, expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset(input string nm);
    @(posedge inclk0); #3;
    rst_n = 1'b0;
    bus.ch_en = '0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0;
`ifdef CLKDIV_SYNC_CLEAR_EN
    bus.sync_clr = 1'b0;
`endif
    #1;
    check({nm, " c0"},     bus.c0,     '0);
    check({nm, " tick"},   bus.tick,   '0);
    check({nm, " locked"}, bus.locked, '0);
    @(posedge inclk0); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] r0, r1;
    logic       c, t, l, c1, t1, l1, we;
    logic [CW-1:0] ch;
    logic [BW-1:0] dt;
    logic [NC-1:0] en;

    // Table A: ch0 at default H=3 straight out of reset
    for (int n = 1; n <= 16; n++) begin
      r0 = run_exp(n, DH);
      ta.push_back(mk(4'b0001, 1'b0, '0, '0, 1'b0, {3'b0, r0[2]}, {3'b0, r0[1]}, {3'b0, r0[0]}));
    end
    // Table B: ch1 written to H=0 while disabled, then enabled (divide-by-2)
    tb_v.push_back(mk(4'b0000, 1'b1, 3'd1, 8'd0, 1'b0, '0, '0, '0));
    tb_v.push_back(mk(4'b0000, 1'b0, 3'd0, 8'd0, 1'b0, '0, '0, '0));
    for (int n = 1; n <= 8; n++) begin
      r1 = run_exp(n, 0);
      tb_v.push_back(mk(4'b0010, 1'b0, '0, '0, 1'b0, {2'b0, r1[2], 1'b0}, {2'b0, r1[1], 1'b0},
                        {2'b0, r1[0], 1'b0}));
    end

    do_reset("rst_init");
    foreach (ta[i]) apply(ta[i], $sformatf("tabA[%0d]", i));
    drain("tabA");

    do_reset("rst_b");
    foreach (tb_v[i]) apply(tb_v[i], $sformatf("tabB[%0d]", i));
    drain("tabB");

    // ch0 H=3, rewrite H=1 mid high half: that half stays 4, then halves of 2
    do_reset("rst_c");
    for (int s = 1; s <= 14; s++) begin
      c = (s >= 4 && s <= 7) || s == 10 || s == 11 || s == 14;
      t = (s == 4) || (s == 10) || (s == 14);
      l = (s == 4) || (s >= 10);
      apply(mk(4'b0001, s == 5, 3'd0, 8'd1, 1'b0, {3'b0, c}, {3'b0, t}, {3'b0, l}),
            $sformatf("midwr s%0d", s));
    end
    drain("midwr");

    // ch2 written H=5 in its terminal cycle; later a write to absent channel 5
    do_reset("rst_d");
    for (int s = 1; s <= 26; s++) begin
      c  = (s >= 4 && s <= 7) || (s >= 14 && s <= 19) || s == 26;
      t  = (s == 4) || (s == 14) || (s == 26);
      l  = (s >= 4 && s <= 7) || (s >= 14);
      c1 = (s >= 25);
      t1 = (s == 25);
      l1 = (s >= 25);
      we = (s == 8) || (s == 21);
      ch = (s == 21) ? 3'd5 : 3'd2;
      dt = (s == 21) ? 8'd0 : 8'd5;
      en = (s >= 22) ? 4'b0110 : 4'b0100;
      apply(mk(en, we, ch, dt, 1'b0, {1'b0, c, c1, 1'b0}, {1'b0, t, t1, 1'b0},
               {1'b0, l, l1, 1'b0}), $sformatf("bypass s%0d", s));
    end
    drain("bypass");

    // Disable ch0 while high, re-enable after two idle cycles
    do_reset("rst_e");
    for (int s = 1; s <= 12; s++) begin
      en = (s == 6 || s == 7) ? 4'b0000 : 4'b0001;
      r0 = (s <= 5) ? run_exp(s, DH) : (s <= 7) ? 3'b000 : run_exp(s - 7, DH);
      apply(mk(en, 1'b0, '0, '0, 1'b0, {3'b0, r0[2]}, {3'b0, r0[1]}, {3'b0, r0[0]}),
            $sformatf("disable s%0d", s));
    end
    drain("disable");
    // ch0 is high here, so the asynchronous reset must pull it down between edges
    do_reset("rst_midrun");

`ifdef CLKDIV_SYNC_CLEAR_EN
    // ch0 H=3 and ch1 H=1 run, are held by sync_clr, then restart from full halves together
    apply(mk(4'b0000, 1'b1, 3'd1, 8'd1, 1'b0, '0, '0, '0), "sclr wr");
    apply(mk(4'b0000, 1'b0, 3'd0, 8'd0, 1'b0, '0, '0, '0), "sclr idle");
    for (int n = 1; n <= 8; n++) begin
      r0 = run_exp(n, DH);
      r1 = run_exp(n, 1);
      apply(mk(4'b0011, 1'b0, '0, '0, 1'b0, {2'b0, r1[2], r0[2]}, {2'b0, r1[1], r0[1]},
               {2'b0, r1[0], r0[0]}), $sformatf("sclr pre n%0d", n));
    end
    for (int n = 1; n <= 2; n++)
      apply(mk(4'b0011, 1'b0, '0, '0, 1'b1, '0, '0, 4'b0011), $sformatf("sclr hold n%0d", n));
    for (int n = 1; n <= 12; n++) begin
      r0 = run_exp(n, DH);
      r1 = run_exp(n, 1);
      apply(mk(4'b0011, 1'b0, '0, '0, 1'b0, {2'b0, r1[2], r0[2]}, {2'b0, r1[1], r0[1]},
               4'b0011), $sformatf("sclr post n%0d", n));
    end
    drain("sclr");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
